// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, start/done handshake.
// Optional two's-complement mode is enabled by defining SEQ_DIVIDER_SIGNED_EN.
module seq_divider #(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [SIZE-1:0] A,
  input  logic [SIZE-1:0] B,
  output logic            busy,
  output logic            done,
  output logic [SIZE-1:0] Q,
  output logic [SIZE-1:0] R,
  output logic            div_by_zero
);

  localparam int CNT_W = $clog2(SIZE + 1);

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [SIZE-1:0]  div_q;
  logic [SIZE-1:0]  p_q;
  logic [SIZE-1:0]  qr_q;

  logic [SIZE:0]    sh_p_d;
  logic [SIZE:0]    trial_d;
  logic             nonneg_d;
  logic [SIZE-1:0]  p_d;
  logic [SIZE-1:0]  qr_d;
  logic [SIZE-1:0]  a_mag_d;
  logic [SIZE-1:0]  b_mag_d;
  logic [SIZE-1:0]  q_res_d;
  logic [SIZE-1:0]  r_res_d;

  // Trial subtraction done as A + ~B + 1 over SIZE+1 bits; MSB set means a borrow.
  function automatic logic [SIZE:0] trial_sub(input logic [SIZE:0]   minuend,
                                              input logic [SIZE-1:0] subtrahend);
    return minuend + ~{1'b0, subtrahend} + {{SIZE{1'b0}}, 1'b1};
  endfunction

  // One shift-and-subtract step of the restoring algorithm.
  always_comb begin
    sh_p_d   = {p_q, qr_q[SIZE-1]};
    trial_d  = trial_sub(sh_p_d, div_q);
    nonneg_d = ~trial_d[SIZE];
    if (nonneg_d) begin
      p_d = trial_d[SIZE-1:0];
    end else begin
      p_d = sh_p_d[SIZE-1:0];
    end
    qr_d = {qr_q[SIZE-2:0], nonneg_d};
  end

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic neg_q_q;
  logic neg_r_q;

  function automatic logic [SIZE-1:0] negate(input logic [SIZE-1:0] x);
    return ~x + {{(SIZE-1){1'b0}}, 1'b1};
  endfunction

  // Operand magnitudes for the unsigned core and sign fix-up of the final result.
  always_comb begin
    if (A[SIZE-1]) begin
      a_mag_d = negate(A);
    end else begin
      a_mag_d = A;
    end
    if (B[SIZE-1]) begin
      b_mag_d = negate(B);
    end else begin
      b_mag_d = B;
    end
    if (neg_q_q) begin
      q_res_d = negate(qr_d);
    end else begin
      q_res_d = qr_d;
    end
    if (neg_r_q) begin
      r_res_d = negate(p_d);
    end else begin
      r_res_d = p_d;
    end
  end
`else
  assign a_mag_d = A;
  assign b_mag_d = B;
  assign q_res_d = qr_d;
  assign r_res_d = p_d;
`endif

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      div_q       <= {SIZE{1'b0}};
      p_q         <= {SIZE{1'b0}};
      qr_q        <= {SIZE{1'b0}};
      busy        <= 1'b0;
      done        <= 1'b0;
      Q           <= {SIZE{1'b0}};
      R           <= {SIZE{1'b0}};
      div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (B != {SIZE{1'b0}}) begin
              div_q       <= b_mag_d;
              qr_q        <= a_mag_d;
              p_q         <= {SIZE{1'b0}};
              cnt_q       <= CNT_W'(SIZE);
              div_by_zero <= 1'b0;
              busy        <= 1'b1;
              state_q     <= CALC;
`ifdef SEQ_DIVIDER_SIGNED_EN
              neg_q_q     <= A[SIZE-1] ^ B[SIZE-1];
              neg_r_q     <= A[SIZE-1];
`endif
            end else begin
              // Divide by zero completes in one edge without entering CALC.
              Q           <= {SIZE{1'b1}};
              R           <= A;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
            end
          end
        end
        CALC: begin
          p_q   <= p_d;
          qr_q  <= qr_d;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            Q       <= q_res_d;
            R       <= r_res_d;
            done    <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Randomised and directed self-checking bench for seq_divider (SIZE=8).
module tb_seq_divider;

  localparam int SIZE = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start_s;
  logic [SIZE-1:0] a_s;
  logic [SIZE-1:0] b_s;
  logic            busy_s;
  logic            done_s;
  logic [SIZE-1:0] q_s;
  logic [SIZE-1:0] r_s;
  logic            dbz_s;

  int tests_run = 0;
  int fails     = 0;

  seq_divider #(.SIZE(SIZE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start_s),
    .A           (a_s),
    .B           (b_s),
    .busy        (busy_s),
    .done        (done_s),
    .Q           (q_s),
    .R           (r_s),
    .div_by_zero (dbz_s)
  );

  always #5 clk = ~clk;

`ifdef SEQ_DIVIDER_SIGNED_EN
  localparam logic [7:0] TA [5] = '{8'hF9, 8'h07, 8'h80, 8'd100, 8'h37};
  localparam logic [7:0] TB [5] = '{8'h02, 8'hFE, 8'hFF, 8'd7,   8'h00};
  localparam logic [7:0] TQ [5] = '{8'hFD, 8'hFD, 8'h80, 8'd14,  8'hFF};
  localparam logic [7:0] TR [5] = '{8'hFF, 8'h01, 8'h00, 8'd2,   8'h37};
  localparam logic       TZ [5] = '{1'b0,  1'b0,  1'b0,  1'b0,   1'b1};
`else
  localparam logic [7:0] TA [5] = '{8'd100, 8'd255, 8'd5, 8'd0, 8'h37};
  localparam logic [7:0] TB [5] = '{8'd7,   8'd1,   8'd9, 8'd3, 8'h00};
  localparam logic [7:0] TQ [5] = '{8'd14,  8'd255, 8'd0, 8'd0, 8'hFF};
  localparam logic [7:0] TR [5] = '{8'd2,   8'd0,   8'd5, 8'd0, 8'h37};
  localparam logic       TZ [5] = '{1'b0,   1'b0,   1'b0, 1'b0, 1'b1};
`endif

  // Reference: plain integer division (truncating in signed mode).
  task automatic model(input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] q, output logic [7:0] r, output logic dbz);
    int sa;
    int sb;
    if (b == 8'd0) begin
      q = 8'hFF; r = a; dbz = 1'b1;
    end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
      sa = $signed(a);
      sb = $signed(b);
`else
      sa = int'(a);
      sb = int'(b);
`endif
      q = 8'(sa / sb); r = 8'(sa % sb); dbz = 1'b0;
    end
  endtask

  // Issue one operation from the current time; returns edges-to-done (0 = timeout).
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        output int lat, output int busy_cnt);
    a_s = a; b_s = b; start_s = 1'b1;
    lat = 0; busy_cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 1) start_s = 1'b0;
      if (busy_s) busy_cnt++;
      if (done_s) begin lat = k; break; end
    end
  endtask

  task automatic check_op(input string name, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] eq, er;
    logic       ez;
    int lat, bc, elat, ebc;
    model(a, b, eq, er, ez);
    elat = ez ? 1 : SIZE + 1;
    ebc  = ez ? 0 : SIZE;
    run_op(a, b, lat, bc);
    tests_run++;
    if (lat !== elat) begin fails++; $display("FAIL %s latency a=%0h b=%0h got %0d want %0d", name, a, b, lat, elat); end
    tests_run++;
    if (bc !== ebc) begin fails++; $display("FAIL %s busy_cycles got %0d want %0d", name, bc, ebc); end
    tests_run++;
    if (q_s !== eq || r_s !== er || dbz_s !== ez) begin
      fails++;
      $display("FAIL %s result a=%0h b=%0h got Q=%0h R=%0h z=%0b want Q=%0h R=%0h z=%0b",
               name, a, b, q_s, r_s, dbz_s, eq, er, ez);
    end
    @(posedge clk); #1;
    tests_run++;
    if (done_s !== 1'b0 || q_s !== eq || r_s !== er) begin
      fails++; $display("FAIL %s hold done=%0b Q=%0h R=%0h want done=0 Q=%0h R=%0h", name, done_s, q_s, r_s, eq, er);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_s = 1'b0; a_s = 8'd0; b_s = 8'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({busy_s, done_s, q_s, r_s, dbz_s} !== 19'd0) begin
      fails++; $display("FAIL reset_state got busy=%0b done=%0b Q=%0h R=%0h z=%0b want all 0", busy_s, done_s, q_s, r_s, dbz_s);
    end
  endtask

  task automatic test_directed();
    for (int i = 0; i < 5; i++) begin
      logic [7:0] eq, er;
      logic       ez;
      model(TA[i], TB[i], eq, er, ez);
      tests_run++;
      if (eq !== TQ[i] || er !== TR[i] || ez !== TZ[i]) begin
        fails++; $display("FAIL model_vs_table %0d got Q=%0h R=%0h want Q=%0h R=%0h", i, eq, er, TQ[i], TR[i]);
      end
      check_op("directed", TA[i], TB[i]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic [7:0] a, b;
      a = 8'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      check_op("random", a, b);
    end
  endtask

  task automatic test_busy_ignore();
    logic [7:0] eq, er;
    logic       ez;
    int lat;
    model(8'd200, 8'd10, eq, er, ez);
    a_s = 8'd200; b_s = 8'd10; start_s = 1'b1;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 1) start_s = 1'b0;
      if (k == 3) begin start_s = 1'b1; a_s = 8'd9;  b_s = 8'd3; end
      if (k == 4) begin start_s = 1'b0; a_s = 8'h55; b_s = 8'd0; end
      if (done_s) begin lat = k; break; end
    end
    tests_run++;
    if (lat !== SIZE + 1) begin fails++; $display("FAIL ignore_latency got %0d want %0d", lat, SIZE + 1); end
    tests_run++;
    if (q_s !== eq || r_s !== er || dbz_s !== 1'b0) begin
      fails++; $display("FAIL ignore_result got Q=%0h R=%0h want Q=%0h R=%0h", q_s, r_s, eq, er);
    end
  endtask

  // Called while done is still high, so the new start lands in the done cycle.
  task automatic test_back_to_back();
    int lat, bc;
    run_op(8'd9, 8'd3, lat, bc);
    tests_run++;
    if (lat !== SIZE + 1) begin fails++; $display("FAIL b2b_latency got %0d want %0d", lat, SIZE + 1); end
    tests_run++;
    if (q_s !== 8'd3 || r_s !== 8'd0) begin fails++; $display("FAIL b2b_result got Q=%0h R=%0h want Q=3 R=0", q_s, r_s); end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    int done_seen;
    a_s = 8'd100; b_s = 8'd7; start_s = 1'b1;
    @(posedge clk); #1; start_s = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({busy_s, done_s, q_s, r_s, dbz_s} !== 19'd0) begin
      fails++; $display("FAIL async_reset got busy=%0b done=%0b Q=%0h R=%0h z=%0b want all 0", busy_s, done_s, q_s, r_s, dbz_s);
    end
    done_seen = 0;
    repeat (3) begin @(posedge clk); #1; if (done_s) done_seen++; end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin @(posedge clk); #1; if (done_s || busy_s) done_seen++; end
    tests_run++;
    if (done_seen !== 0) begin fails++; $display("FAIL aborted_op activity got %0d want 0", done_seen); end
    @(negedge clk);
    check_op("after_reset", 8'd100, 8'd7);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_busy_ignore();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
